issue_packet_buffer: RTL
========================

Name: issue_packet_buffer

Overview:
- Successor to the single-enqueue instruction FIFO that feeds the Garuda issue stage.
- Accepts up to ENQ_WIDTH instructions per cycle from the CVXIF front end.
- Presents up to ISSUE_WIDTH in-order head instructions per cycle, trimmed at the first intra-packet register hazard.
- The consumer may take any prefix of the packet (partial accept); a flush empties the buffer in one cycle.

Parameters:
- DEPTH, 16, entry count; power of two, >= max(ENQ_WIDTH, ISSUE_WIDTH).
- ENQ_WIDTH, 2, enqueue lanes per cycle (1-4).
- ISSUE_WIDTH, 4, issue slots per cycle (1-8).
- INSTR_WIDTH, 32, instruction word width.
- REG_W, 5, register address width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all entries.
- enq_valid_i  in  ENQ_WIDTH  per-lane enqueue request.
- enq_instr_i  in  ENQ_WIDTH x INSTR_WIDTH  instruction words.
- enq_rs1_i, enq_rs2_i, enq_rd_i  in  ENQ_WIDTH x REG_W  register addresses.
- enq_ready_o  out  1  buffer can take ENQ_WIDTH entries this cycle.
- issue_valid_o  out  1  issue_mask_o nonzero.
- issue_mask_o  out  ISSUE_WIDTH  contiguous-from-slot-0 valid slots.
- issue_instr_o  out  ISSUE_WIDTH x INSTR_WIDTH  slot payload.
- issue_rs1_o, issue_rs2_o, issue_rd_o  out  ISSUE_WIDTH x REG_W  slot registers.
- issue_accept_i  in  $clog2(ISSUE_WIDTH+1)  slots taken this cycle (prefix count).
- hazard_cut_o  out  1  packet was trimmed by a hazard rather than by occupancy.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- full_o, empty_o  out  1  count_o==DEPTH / count_o==0.

Behaviour:
- Reset (rst_i=1 at edge): pointers and count set to 0; storage need not clear.
  - Outputs the cycle after reset: issue_valid_o=0, mask=0, all payloads 0, hazard_cut_o=0, enq_ready_o=1, empty_o=1, full_o=0, count_o=0.
  - Reset mid-operation drops all entries; enqueues presented that cycle are dropped.
- Enqueue:
  - enq_ready_o = (DEPTH - count_q) >= ENQ_WIDTH. It is computed from registered count only; a same-cycle pop gives no credit.
  - When enq_ready_o=1, the valid lanes are written in ascending lane order to consecutive slots starting at wr_ptr. Non-contiguous valid lanes are compacted.
  - n_enq = popcount(enq_valid_i). When enq_ready_o=0, nothing is written.
  - Written entries become visible on issue outputs the next cycle; there is no bypass.
- Issue window: slot k maps to entry (rd_ptr+k) mod DEPTH, for k < min(count_q, ISSUE_WIDTH).
  - Slot k is valid iff slots 0..k-1 are valid and slot k has no hazard against any earlier slot j<k. A hazard is RAW, WAR or WAW:
    - RAW: rs1_k or rs2_k == rd_j.
    - WAR: rd_k == rs1_j or rs2_j.
    - WAW: rd_k == rd_j.
  - Comparisons involving register 0 never match.
  - Slot 0 is always valid when count_q>0.
  - hazard_cut_o=1 iff the mask is shorter than min(count_q, ISSUE_WIDTH).
  - Payloads of invalid slots drive 0. All issue outputs are combinational from registered state.
- Pop: n_pop = min(issue_accept_i, popcount(issue_mask_o)); oversize accepts are clamped.
  - rd_ptr advances by n_pop mod DEPTH.
  - issue_accept_i=0 holds the packet unchanged.
- Count: count_d = count_q + n_enq - n_pop. Simultaneous enqueue and pop are both honoured. Pointers wrap modulo DEPTH.
- Flush (flush_i=1, rst_i=0): next cycle count=0 and rd_ptr=wr_ptr. Same-cycle enqueue and pop are ignored. Flush has priority over both.
- Priority: rst_i > flush_i > normal operation.

Test Plan:
- Reset, then enqueue 2 independent instrs/cycle for 8 cycles with issue_accept_i=0 -> count_o=16, full_o=1, enq_ready_o=0 from count 15 onward; the 9th pair is not written.
- Fill 4 entries: rd=1; rs1=1 (RAW); rd=3; rd=4 -> mask=4'b0001, hazard_cut_o=1. Accept 1 -> next mask=4'b0111 (rd=3 and rd=4 do not hit rs1=1).
- x0 cases: slot0 rd=0, slot1 rs1=0 rd=0 -> no hazard, mask covers both.
- Partial accept: mask=4'b1111, issue_accept_i=2 -> count drops by 2 and the new slot0 is the old slot2. issue_accept_i=7 with mask 4'b0011 -> clamped, pops 2.
- Wrap: cycle enqueue 2 / accept 2 for 40 cycles across the DEPTH=16 boundary -> FIFO order preserved, count stays constant, no duplicated or lost instruction.
- Flush with count=9 plus a concurrent enqueue of 2 and accept of 3 -> next cycle count_o=0, empty_o=1, issue_valid_o=0. Assert rst_i while full -> same empty state; a subsequent enqueue issues correctly from slot 0.

Source files
------------

// File: rtl/issue_packet_buffer_if.sv
// Enqueue/issue bundle between the CVXIF front end, the packet buffer and the issue stage.
// The slave modport is the buffer's view; the master modport is the surrounding pipeline's view.
interface issue_packet_buffer_if #(
    parameter int DEPTH       = 16,
    parameter int ENQ_WIDTH   = 2,
    parameter int ISSUE_WIDTH = 4,
    parameter int INSTR_WIDTH = 32,
    parameter int REG_W       = 5
);
    localparam int ACC_W = $clog2(ISSUE_WIDTH + 1);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                                     flush_i;
    logic [ENQ_WIDTH-1:0]                     enq_valid_i;
    logic [ENQ_WIDTH-1:0][INSTR_WIDTH-1:0]    enq_instr_i;
    logic [ENQ_WIDTH-1:0][REG_W-1:0]          enq_rs1_i;
    logic [ENQ_WIDTH-1:0][REG_W-1:0]          enq_rs2_i;
    logic [ENQ_WIDTH-1:0][REG_W-1:0]          enq_rd_i;
    logic                                     enq_ready_o;
    logic                                     issue_valid_o;
    logic [ISSUE_WIDTH-1:0]                   issue_mask_o;
    logic [ISSUE_WIDTH-1:0][INSTR_WIDTH-1:0]  issue_instr_o;
    logic [ISSUE_WIDTH-1:0][REG_W-1:0]        issue_rs1_o;
    logic [ISSUE_WIDTH-1:0][REG_W-1:0]        issue_rs2_o;
    logic [ISSUE_WIDTH-1:0][REG_W-1:0]        issue_rd_o;
    logic [ACC_W-1:0]                         issue_accept_i;
    logic                                     hazard_cut_o;
    logic [CNT_W-1:0]                         count_o;
    logic                                     full_o;
    logic                                     empty_o;

    modport slave (
        input  flush_i, enq_valid_i, enq_instr_i, enq_rs1_i, enq_rs2_i, enq_rd_i, issue_accept_i,
        output enq_ready_o, issue_valid_o, issue_mask_o, issue_instr_o, issue_rs1_o, issue_rs2_o,
               issue_rd_o, hazard_cut_o, count_o, full_o, empty_o
    );

    modport master (
        output flush_i, enq_valid_i, enq_instr_i, enq_rs1_i, enq_rs2_i, enq_rd_i, issue_accept_i,
        input  enq_ready_o, issue_valid_o, issue_mask_o, issue_instr_o, issue_rs1_o, issue_rs2_o,
               issue_rd_o, hazard_cut_o, count_o, full_o, empty_o
    );
endinterface

// File: rtl/issue_packet_buffer.sv
// Multi-enqueue instruction buffer presenting an in-order issue packet trimmed at the
// first intra-packet RAW/WAR/WAW hazard; the consumer pops any prefix of the packet.
module issue_packet_buffer #(
    parameter int DEPTH       = 16,
    parameter int ENQ_WIDTH   = 2,
    parameter int ISSUE_WIDTH = 4,
    parameter int INSTR_WIDTH = 32,
    parameter int REG_W       = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    issue_packet_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ACC_W = $clog2(ISSUE_WIDTH + 1);
    localparam logic [CNT_W-1:0] ENQ_LIMIT = CNT_W'(DEPTH - ENQ_WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ISSUE_C   = CNT_W'(ISSUE_WIDTH);

    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [REG_W-1:0]       rs1_q   [DEPTH];
    logic [REG_W-1:0]       rs2_q   [DEPTH];
    logic [REG_W-1:0]       rd_q    [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic                              enq_ready, enq_fire;
    logic [CNT_W-1:0]                  n_enq;
    logic [ENQ_WIDTH-1:0][PTR_W-1:0]   wr_idx;
    logic [ISSUE_WIDTH-1:0][PTR_W-1:0] rd_idx;
    logic [ISSUE_WIDTH-1:0]            hazard, mask;
    logic [ACC_W-1:0]                  n_avail, n_valid, n_pop;
    logic                              open;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a == b) && (a != '0);
    endfunction

    assign enq_ready = (count_q <= ENQ_LIMIT);
    assign enq_fire  = enq_ready && !bus.flush_i && !rst_i;

    // Valid lanes are compacted onto consecutive slots from wr_ptr.
    always_comb begin
        n_enq = '0;
        for (int l = 0; l < ENQ_WIDTH; l++) begin
            wr_idx[l] = wr_ptr_q + n_enq[PTR_W-1:0];
            if (bus.enq_valid_i[l]) n_enq = n_enq + CNT_W'(1);
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) rd_idx[k] = rd_ptr_q + PTR_W'(k);
    end

    always_comb begin
        hazard  = '0;
        mask    = '0;
        n_valid = '0;
        open    = 1'b1;
        n_avail = (count_q < ISSUE_C) ? ACC_W'(count_q) : ACC_W'(ISSUE_WIDTH);
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            for (int j = 0; j < k; j++) begin
                if (reg_hit(rs1_q[rd_idx[k]], rd_q[rd_idx[j]]) ||
                    reg_hit(rs2_q[rd_idx[k]], rd_q[rd_idx[j]]) ||
                    reg_hit(rd_q[rd_idx[k]], rs1_q[rd_idx[j]]) ||
                    reg_hit(rd_q[rd_idx[k]], rs2_q[rd_idx[j]]) ||
                    reg_hit(rd_q[rd_idx[k]], rd_q[rd_idx[j]]))
                    hazard[k] = 1'b1;
            end
            if (open && (ACC_W'(k) < n_avail) && !hazard[k]) begin
                mask[k] = 1'b1;
                n_valid = n_valid + ACC_W'(1);
            end else begin
                open = 1'b0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            bus.issue_instr_o[k] = mask[k] ? instr_q[rd_idx[k]] : '0;
            bus.issue_rs1_o[k]   = mask[k] ? rs1_q[rd_idx[k]]   : '0;
            bus.issue_rs2_o[k]   = mask[k] ? rs2_q[rd_idx[k]]   : '0;
            bus.issue_rd_o[k]    = mask[k] ? rd_q[rd_idx[k]]    : '0;
        end
    end

    assign n_pop = (bus.issue_accept_i > n_valid) ? n_valid : bus.issue_accept_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
            if (enq_fire) wr_ptr_d = wr_ptr_q + n_enq[PTR_W-1:0];
            count_d = count_q + (enq_fire ? n_enq : '0) - CNT_W'(n_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            for (int l = 0; l < ENQ_WIDTH; l++) begin
                if (bus.enq_valid_i[l]) begin
                    instr_q[wr_idx[l]] <= bus.enq_instr_i[l];
                    rs1_q[wr_idx[l]]   <= bus.enq_rs1_i[l];
                    rs2_q[wr_idx[l]]   <= bus.enq_rs2_i[l];
                    rd_q[wr_idx[l]]    <= bus.enq_rd_i[l];
                end
            end
        end
    end

    assign bus.enq_ready_o   = enq_ready;
    assign bus.issue_mask_o  = mask;
    assign bus.issue_valid_o = mask[0];
    assign bus.hazard_cut_o  = (n_valid < n_avail);
    assign bus.count_o       = count_q;
    assign bus.full_o        = (count_q == DEPTH_C);
    assign bus.empty_o       = (count_q == '0);
endmodule
